// File: rtl/cpu19_pkg.sv
// cpu19_pkg: shared definitions for the 19-bit CPU control path.
//   - instruction field positions and widths
//   - opcode constants used by the classifier
//   - sequencer state enumeration
package cpu19_pkg;

    localparam int INSN_W = 19;

    // Instruction fields: opcode[18:14] r1[13:11] r2[10:8] r3[7:5] imm5[4:0]
    localparam int OPC_HI = 18;
    localparam int OPC_LO = 14;
    localparam int OPC_W  = 5;
    localparam int R1_HI  = 13;
    localparam int R1_LO  = 11;
    localparam int R2_HI  = 10;
    localparam int R2_LO  = 8;
    localparam int R3_HI  = 7;
    localparam int R3_LO  = 5;
    localparam int IMM_HI = 4;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 5;
    localparam int JMP_W  = 14;   // jump target is ir[13:0]

    // Opcode map
    localparam logic [OPC_W-1:0] OP_ALU_LAST   = 5'b01010;  // ALU is 00000..01010
    localparam logic [OPC_W-1:0] OP_LOAD       = 5'b01011;
    localparam logic [OPC_W-1:0] OP_STORE      = 5'b01100;
    localparam logic [OPC_W-1:0] OP_JUMP       = 5'b11000;
    localparam logic [OPC_W-1:0] OP_HALT       = 5'b11111;
    localparam logic [2:0]       OP_BRANCH_PFX = 3'b101;    // opcode[4:2]

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/cpu19_decode.sv
// cpu19_decode: combinational opcode classifier.
// Ports:
//   opcode      in  5  instruction opcode field
//   is_alu      out 1  00000..01010
//   is_load     out 1  01011
//   is_store    out 1  01100
//   is_branch   out 1  opcode[4:2] == 101
//   is_jump     out 1  11000
//   is_halt     out 1  11111
//   is_illegal  out 1  none of the above
module cpu19_decode
    import cpu19_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_alu,
    output logic             is_load,
    output logic             is_store,
    output logic             is_branch,
    output logic             is_jump,
    output logic             is_halt,
    output logic             is_illegal
);

    assign is_alu     = (opcode <= OP_ALU_LAST);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_branch  = (opcode[4:2] == OP_BRANCH_PFX);
    assign is_jump    = (opcode == OP_JUMP);
    assign is_halt    = (opcode == OP_HALT);
    assign is_illegal = ~(is_alu | is_load | is_store | is_branch | is_jump | is_halt);

endmodule

// File: rtl/cpu19_sequencer.sv
// cpu19_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM control sequencer.
// Owns pc and ir, drives the shared memory port (req/ready) and the
// register-file write strobe.
// Optional feature macro: CPU19_TRAP_EN (illegal opcode halts with trap=1;
// when undefined, illegal opcodes execute as NOPs and trap is tied 0).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_req/mem_we/mem_addr memory request, store flag, address
//   mem_ready, mem_rdata    access completion and read data
//   dp_addr                 load/store effective address from the datapath
//   br_cond                 branch condition, sampled in EXEC
//   ir, pc                  instruction register, program counter
//   rf_we, wb_sel           register write strobe, writeback source select
//   halted, trap            sticky stop and illegal-opcode flags
module cpu19_sequencer
    import cpu19_pkg::*;
#(
    parameter int ADDR_W = 16   // must be >= 14 so a jump target fits
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [INSN_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic              br_cond,
    output logic [INSN_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              halted,
    output logic              trap
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [INSN_W-1:0]   ir_reg, ir_next;
    logic [ADDR_W-1:0]   br_off;
    logic [ADDR_W-1:0]   jmp_target;

    logic is_alu, is_load, is_store, is_branch, is_jump, is_halt, is_illegal;

    cpu19_decode u_decode (
        .opcode     (ir_reg[OPC_HI:OPC_LO]),
        .is_alu     (is_alu),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign br_off = {{(ADDR_W-IMM_W){ir_reg[IMM_HI]}}, ir_reg[IMM_HI:IMM_LO]};

    // Built by field assignment so ADDR_W == 14 needs no zero-width pad.
    always_comb begin
        jmp_target              = '0;
        jmp_target[JMP_W-1:0]   = ir_reg[JMP_W-1:0];
    end

`ifdef CPU19_TRAP_EN
    logic trap_reg, trap_next;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
`ifdef CPU19_TRAP_EN
        trap_next  = trap_reg;
`endif
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_reg + ADDR_W'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = ST_FETCH;
                if (is_branch && br_cond) pc_next = pc_reg + br_off;
                if (is_jump)              pc_next = jmp_target;
                if (is_load || is_store)  state_next = ST_MEM;
                if (is_halt)              state_next = ST_HALT;
                if (is_illegal) begin
`ifdef CPU19_TRAP_EN
                    state_next = ST_HALT;
                    trap_next  = 1'b1;
`else
                    state_next = ST_FETCH;
`endif
                end
            end
            ST_MEM: begin
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

`ifdef CPU19_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_reg <= 1'b0;
        else        trap_reg <= trap_next;
    end
    assign trap = trap_reg;
`else
    assign trap = 1'b0;
`endif

    // The reset state is FETCH, so the request decode is qualified with
    // rst_n: the port goes idle the instant reset asserts and stays idle
    // while it is held.
    assign mem_req  = rst_n && ((state_reg == ST_FETCH) || (state_reg == ST_MEM));
    assign mem_we   = rst_n && (state_reg == ST_MEM) && is_store;
    assign mem_addr = (state_reg == ST_MEM) ? dp_addr : pc_reg;

    // Load writeback strobes only in the completing cycle of the access.
    assign rf_we  = ((state_reg == ST_EXEC) && is_alu) ||
                    ((state_reg == ST_MEM) && is_load && mem_ready);
    assign wb_sel = (state_reg == ST_MEM) && is_load;
    assign halted = (state_reg == ST_HALT);

    assign ir = ir_reg;
    assign pc = pc_reg;

endmodule

// File: tb/tb_cpu19_sequencer.sv
// tb_cpu19_sequencer: directed bench for cpu19_sequencer.
// An instruction-level model walks the program held in the bench memory
// and expands each instruction into its expected per-cycle port activity;
// every cycle is compared against the DUT, plus literal spot checks.
module tb_cpu19_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [18:0] mem_rdata = '0;
    logic [15:0] dp_addr;
    logic        br_cond;
    logic [18:0] ir;
    logic [15:0] pc;
    logic        rf_we, wb_sel, halted, trap;

    always #5 clk = ~clk;

    cpu19_sequencer #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .dp_addr   (dp_addr),
        .br_cond   (br_cond),
        .ir        (ir),
        .pc        (pc),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .trap      (trap)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- memory responder ----------------
    logic [18:0] imem [logic [15:0]];
    int   wait_n = 0;
    logic noise  = 1'b0;   // assert mem_ready outside requests (must be ignored)
    int   rcnt   = 0;

    function automatic logic [18:0] rd(logic [15:0] a);
        if (imem.exists(a)) return imem[a];
        return 19'h0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            rcnt      = 0;
        end else if (mem_req) begin
            mem_rdata = rd(mem_addr);
            if (rcnt >= wait_n) begin
                mem_ready = 1'b1;
                rcnt      = 0;
            end else begin
                mem_ready = 1'b0;
                rcnt++;
            end
        end else begin
            mem_ready = noise;
            mem_rdata = 19'h7FFFF;
            rcnt      = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    typedef struct {
        logic        req, we, rfwe, wbsel, hlt, trp;
        logic [15:0] addr, pc;
        logic [18:0] ir;
    } row_t;

    row_t        exp_q[$];
    logic [15:0] m_pc;
    logic [18:0] m_ir;

    function automatic row_t mkrow(logic req, logic we, logic [15:0] addr, logic rfwe,
                                   logic wbsel, logic hlt, logic trp,
                                   logic [15:0] p, logic [18:0] i);
        row_t r;
        r.req = req; r.we = we; r.addr = addr; r.rfwe = rfwe; r.wbsel = wbsel;
        r.hlt = hlt; r.trp = trp; r.pc = p; r.ir = i;
        return r;
    endfunction

    function automatic logic [18:0] mk(logic [4:0] op, logic [13:0] rest);
        return {op, rest};
    endfunction

    // Expand n instructions starting at m_pc into expected cycles.
    task automatic build(int n);
        logic [15:0] p, p1;
        logic [18:0] i;
        logic [4:0]  op;
        logic alu, ld, st, br, jmp, hl, ill, stop;
        for (int k = 0; k < n; k++) begin
            p  = m_pc;
            i  = rd(p);
            op = i[18:14];
            alu = (op <= 5'd10);
            ld  = (op == 5'd11);
            st  = (op == 5'd12);
            br  = (op >= 5'd20 && op <= 5'd23);
            jmp = (op == 5'd24);
            hl  = (op == 5'd31);
            ill = !(alu || ld || st || br || jmp || hl);
            for (int w = 0; w <= wait_n; w++)
                exp_q.push_back(mkrow(1, 0, p, 0, 0, 0, 0, p, m_ir));
            p1   = p + 16'd1;
            m_ir = i;
            m_pc = p1;
            exp_q.push_back(mkrow(0, 0, 0, 0, 0, 0, 0, p1, i));      // decode
            exp_q.push_back(mkrow(0, 0, 0, alu, 0, 0, 0, p1, i));    // exec
            if (br && br_cond) m_pc = p1 + {{11{i[4]}}, i[4:0]};
            if (jmp)           m_pc = {2'b00, i[13:0]};
            if (ld || st)
                for (int w = 0; w <= wait_n; w++)
                    exp_q.push_back(mkrow(1, st, dp_addr, ld && (w == wait_n),
                                          ld && (w == wait_n), 0, 0, p1, i));
            stop = hl;
`ifdef CPU19_TRAP_EN
            stop = hl || ill;
`endif
            if (stop) begin
                for (int c = 0; c < 100; c++)
                    exp_q.push_back(mkrow(0, 0, 0, 0, 0, 1, ill, p1, i));
                break;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare up to k expected cycles (k < 0: all), one per negedge.
    task automatic run_rows(string tag, int k);
        row_t r;
        int   idx = 0;
        while (exp_q.size() > 0 && (k < 0 || idx < k)) begin
            @(negedge clk); #1;
            r = exp_q.pop_front();
            chk($sformatf("%s[%0d] mem_req", tag, idx), mem_req, r.req);
            if (r.req) begin
                chk($sformatf("%s[%0d] mem_we", tag, idx), mem_we, r.we);
                chk($sformatf("%s[%0d] mem_addr", tag, idx), mem_addr, r.addr);
            end
            chk($sformatf("%s[%0d] rf_we", tag, idx), rf_we, r.rfwe);
            if (r.rfwe) chk($sformatf("%s[%0d] wb_sel", tag, idx), wb_sel, r.wbsel);
            chk($sformatf("%s[%0d] halted", tag, idx), halted, r.hlt);
            chk($sformatf("%s[%0d] trap", tag, idx), trap, r.trp);
            chk($sformatf("%s[%0d] pc", tag, idx), pc, r.pc);
            chk($sformatf("%s[%0d] ir", tag, idx), ir, r.ir);
            idx++;
        end
        $display("%s: %0d cycles compared", tag, idx);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst rf_we", rf_we, 0);
        chk("rst wb_sel", wb_sel, 0);
        chk("rst halted", halted, 0);
        chk("rst trap", trap, 0);
        chk("rst pc", pc, 0);
        chk("rst ir", ir, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        m_pc  = 16'h0;
        m_ir  = 19'h0;
    endtask

    task automatic next_fetch(string tag, logic [15:0] a);
        @(negedge clk); #1;
        chk({tag, " next mem_req"}, mem_req, 1);
        chk({tag, " next mem_addr"}, mem_addr, a);
    endtask

    initial begin
        rst_n   = 1'b0;
        dp_addr = 16'h0;
        br_cond = 1'b0;

        // T1: ALU, zero wait, stray ready outside requests
        imem.delete();
        imem[16'h0] = mk(5'b00001, 14'h0123);
        wait_n = 0; noise = 1'b1;
        do_reset();
        build(1);
        run_rows("alu", -1);
        next_fetch("alu", 16'h0001);
        chk("alu pc", pc, 16'h0001);

        // T2: LOAD / STORE / ALU with 2 wait states
        imem.delete();
        imem[16'h0] = mk(5'b01011, 14'h0801);
        imem[16'h1] = mk(5'b01100, 14'h0402);
        imem[16'h2] = mk(5'b01010, 14'h0003);
        wait_n = 2; noise = 1'b0; dp_addr = 16'h0040;
        do_reset();
        build(3);
        run_rows("ldst", -1);
        next_fetch("ldst", 16'h0003);

        // T3: jump to 0x0010, branch taken (imm -2) -> 0x000F
        imem.delete();
        imem[16'h0]  = mk(5'b11000, 14'h0010);
        imem[16'h10] = mk(5'b10100, {9'h0, 5'b11110});
        wait_n = 1; br_cond = 1'b1;
        do_reset();
        build(2);
        run_rows("br_t", -1);
        next_fetch("br_t", 16'h000F);

        // T4: same branch (other branch opcode) not taken -> 0x0011
        imem[16'h10] = mk(5'b10111, {9'h0, 5'b11110});
        br_cond = 1'b0;
        do_reset();
        build(2);
        run_rows("br_n", -1);
        next_fetch("br_n", 16'h0011);

        // T5: jump 0x1234
        imem.delete();
        imem[16'h0] = mk(5'b11000, 14'h1234);
        wait_n = 0;
        do_reset();
        build(1);
        run_rows("jmp", -1);
        next_fetch("jmp", 16'h1234);

        // T6: branch back to 0xFFFF, fetch there wraps pc to 0
        imem.delete();
        imem[16'h0]    = mk(5'b10101, {9'h0, 5'b11110});
        imem[16'hFFFF] = mk(5'b00010, 14'h0);
        br_cond = 1'b1;
        do_reset();
        build(2);
        run_rows("wrap", -1);
        next_fetch("wrap", 16'h0000);
        chk("wrap pc", pc, 16'h0000);

        // T7: HALT, 100 idle cycles with stray ready, then reset restarts
        imem.delete();
        imem[16'h0] = mk(5'b11111, 14'h0);
        br_cond = 1'b0; noise = 1'b1;
        do_reset();
        build(1);
        run_rows("halt", -1);
        chk("halt halted", halted, 1);
        chk("halt mem_req", mem_req, 0);
        imem[16'h0] = mk(5'b00011, 14'h0);
        do_reset();
        next_fetch("restart", 16'h0000);
        noise = 1'b0;

        // T8: illegal opcode 01110
        imem.delete();
        imem[16'h0] = mk(5'b01110, 14'h0);
        do_reset();
        build(1);
`ifdef CPU19_TRAP_EN
        run_rows("ill", -1);
        chk("ill trap", trap, 1);
        chk("ill halted", halted, 1);
`else
        run_rows("ill", -1);
        next_fetch("ill", 16'h0001);
        chk("ill trap", trap, 0);
`endif

        // T9: reset asserted in the middle of a waited LOAD access
        imem.delete();
        imem[16'h0] = mk(5'b01011, 14'h0);
        wait_n = 3; dp_addr = 16'h0200;
        do_reset();
        build(1);
        run_rows("midrst", 7);      // 4 fetch + decode + exec + first MEM cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req", mem_req, 0);
        chk("midrst mem_we", mem_we, 0);
        chk("midrst rf_we", rf_we, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk($sformatf("midrst hold[%0d] rf_we", c), rf_we, 0);
            chk($sformatf("midrst hold[%0d] mem_req", c), mem_req, 0);
        end
        do_reset();
        next_fetch("midrst", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
